// File: rtl/cache_controller_if.sv
// CPU load/store port and memory bus bundle seen by cache_controller.
// The controller uses the slave modport; the CPU/memory side uses master.
interface cache_controller_if;
  // Handshakes: a transfer happens on a rising edge where valid && ready are both 1.
  // The initiator holds its payload stable while valid is high and ready is low.
  logic         cpu_req_valid;
  logic         cpu_req_ready;
  logic         cpu_req_write;
  logic [31:0]  cpu_req_addr;
  logic [31:0]  cpu_req_wdata;
  logic [3:0]   cpu_req_be;
  logic         cpu_resp_valid;
  logic [31:0]  cpu_resp_rdata;
  logic         mem_req_valid;
  logic         mem_req_ready;
  logic         mem_req_write;
  logic [31:0]  mem_req_addr;
  logic [31:0]  mem_req_wdata;
  logic [3:0]   mem_req_be;
  logic         mem_resp_valid;
  logic [255:0] mem_resp_data;

  modport slave (
    input  cpu_req_valid, cpu_req_write, cpu_req_addr, cpu_req_wdata, cpu_req_be,
    input  mem_req_ready, mem_resp_valid, mem_resp_data,
    output cpu_req_ready, cpu_resp_valid, cpu_resp_rdata,
    output mem_req_valid, mem_req_write, mem_req_addr, mem_req_wdata, mem_req_be
  );

  modport master (
    output cpu_req_valid, cpu_req_write, cpu_req_addr, cpu_req_wdata, cpu_req_be,
    output mem_req_ready, mem_resp_valid, mem_resp_data,
    input  cpu_req_ready, cpu_resp_valid, cpu_resp_rdata,
    input  mem_req_valid, mem_req_write, mem_req_addr, mem_req_wdata, mem_req_be
  );
endinterface

// File: rtl/cache_controller.sv
// Blocking write-through, no-write-allocate controller for a 2-set x 4-way, 32-byte-line cache.
// Define CACHE_PLRU_EN for tree pseudo-LRU replacement; otherwise per-set round-robin is used.
module cache_controller (
  input  logic               clk,
  input  logic               reset,
  cache_controller_if.slave  bus,
  output logic [31:0]        we0,
  output logic [31:0]        we1,
  output logic [31:0]        we2,
  output logic [31:0]        we3,
  output logic [31:0]        we4,
  output logic [31:0]        we5,
  output logic [31:0]        we6,
  output logic [31:0]        we7,
  output logic [255:0]       block,
  input  logic [255:0]       blockOut0,
  input  logic [255:0]       blockOut1,
  input  logic [255:0]       blockOut2,
  input  logic [255:0]       blockOut3,
  input  logic [255:0]       blockOut4,
  input  logic [255:0]       blockOut5,
  input  logic [255:0]       blockOut6,
  input  logic [255:0]       blockOut7,
  output logic [2:0]         dbg_state
);

  typedef enum logic [2:0] {
    IDLE        = 3'd0,
    LOOKUP      = 3'd1,
    MEM_WRITE   = 3'd2,
    REFILL_REQ  = 3'd3,
    REFILL_WAIT = 3'd4,
    RESPOND     = 3'd5
  } state_t;

  state_t       state;
  logic         req_write;
  logic [31:0]  req_addr;
  logic [31:0]  req_wdata;
  logic [3:0]   req_be;
  logic [25:0]  tag_q [8];
  logic [7:0]   valid_q;
  logic [1:0]   victim_q;

  logic         req_set;
  logic [2:0]   req_word;
  logic [25:0]  req_tag;
  logic [2:0]   fill_line;
  logic         unused_addr_bits;

  assign req_set          = req_addr[5];
  assign req_word         = req_addr[4:2];
  assign req_tag          = req_addr[31:6];
  assign fill_line        = {req_set, victim_q};
  assign unused_addr_bits = ^bus.cpu_req_addr[1:0];
  assign dbg_state        = state;

  logic [255:0] lines [8];
  assign lines[0] = blockOut0;
  assign lines[1] = blockOut1;
  assign lines[2] = blockOut2;
  assign lines[3] = blockOut3;
  assign lines[4] = blockOut4;
  assign lines[5] = blockOut5;
  assign lines[6] = blockOut6;
  assign lines[7] = blockOut7;

  logic [1:0] policy_way;

`ifdef CACHE_PLRU_EN
  // Tree bits: [0] root (0 = left pair), [1] ways 0/1 (0 = way0), [2] ways 2/3 (0 = way2).
  logic [2:0] plru_q [2];

  function automatic logic [2:0] plru_touch(input logic [2:0] t, input logic [1:0] way);
    logic [2:0] n;
    n    = t;
    n[0] = ~way[1];
    if (way[1]) n[2] = ~way[0];
    else        n[1] = ~way[0];
    return n;
  endfunction

  assign policy_way = plru_q[req_set][0] ? {1'b1, plru_q[req_set][2]}
                                         : {1'b0, plru_q[req_set][1]};
`else
  logic [1:0] rr_q [2];
  assign policy_way = rr_q[req_set];
`endif

  logic [3:0]  hit_vec;
  logic        hit;
  logic [1:0]  hit_way;
  logic [2:0]  hit_line;
  logic [31:0] hit_word;
  logic [1:0]  victim_way;

  always_comb begin
    hit_vec = '0;
    for (int w = 0; w < 4; w++)
      hit_vec[w] = valid_q[{req_set, 2'(w)}] && (tag_q[{req_set, 2'(w)}] == req_tag);
    hit     = |hit_vec;
    hit_way = 2'd0;
    for (int w = 3; w >= 0; w--)
      if (hit_vec[w]) hit_way = 2'(w);
    hit_line = {req_set, hit_way};
    hit_word = lines[hit_line][{req_word, 5'd0} +: 32];
    // Lowest invalid way wins; the policy only decides when the set is full.
    victim_way = policy_way;
    for (int w = 3; w >= 0; w--)
      if (!valid_q[{req_set, 2'(w)}]) victim_way = 2'(w);
  end

  logic [31:0] we_v [8];

  always_comb begin
    for (int i = 0; i < 8; i++) we_v[i] = '0;
    block = '0;
    if (state == LOOKUP && req_write && hit) begin
      we_v[hit_line] = {28'd0, req_be} << {req_word, 2'b00};
      block          = {8{req_wdata}};
    end else if (state == REFILL_WAIT && bus.mem_resp_valid) begin
      we_v[fill_line] = '1;
      block           = bus.mem_resp_data;
    end
  end

  assign we0 = we_v[0];
  assign we1 = we_v[1];
  assign we2 = we_v[2];
  assign we3 = we_v[3];
  assign we4 = we_v[4];
  assign we5 = we_v[5];
  assign we6 = we_v[6];
  assign we7 = we_v[7];

  always_ff @(posedge clk) begin
    if (reset) begin
      state              <= IDLE;
      valid_q            <= '0;
      victim_q           <= '0;
      req_write          <= 1'b0;
      req_addr           <= '0;
      req_wdata          <= '0;
      req_be             <= '0;
      bus.cpu_req_ready  <= 1'b1;
      bus.cpu_resp_valid <= 1'b0;
      bus.cpu_resp_rdata <= '0;
      bus.mem_req_valid  <= 1'b0;
      bus.mem_req_write  <= 1'b0;
      bus.mem_req_addr   <= '0;
      bus.mem_req_wdata  <= '0;
      bus.mem_req_be     <= '0;
`ifdef CACHE_PLRU_EN
      plru_q[0] <= '0;
      plru_q[1] <= '0;
`else
      rr_q[0] <= '0;
      rr_q[1] <= '0;
`endif
    end else begin
      bus.cpu_resp_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.cpu_req_valid) begin
            req_write         <= bus.cpu_req_write;
            req_addr          <= {bus.cpu_req_addr[31:2], 2'b00};
            req_wdata         <= bus.cpu_req_wdata;
            req_be            <= bus.cpu_req_be;
            bus.cpu_req_ready <= 1'b0;
            state             <= LOOKUP;
          end
        end
        LOOKUP: begin
`ifdef CACHE_PLRU_EN
          if (hit) plru_q[req_set] <= plru_touch(plru_q[req_set], hit_way);
`endif
          if (req_write) begin
            bus.mem_req_valid <= 1'b1;
            bus.mem_req_write <= 1'b1;
            bus.mem_req_addr  <= req_addr;
            bus.mem_req_wdata <= req_wdata;
            bus.mem_req_be    <= req_be;
            state             <= MEM_WRITE;
          end else if (hit) begin
            bus.cpu_resp_rdata <= hit_word;
            bus.cpu_resp_valid <= 1'b1;
            state              <= RESPOND;
          end else begin
            victim_q          <= victim_way;
            bus.mem_req_valid <= 1'b1;
            bus.mem_req_write <= 1'b0;
            bus.mem_req_addr  <= {req_addr[31:5], 5'd0};
            bus.mem_req_wdata <= '0;
            bus.mem_req_be    <= '0;
            state             <= REFILL_REQ;
          end
        end
        MEM_WRITE: begin
          if (bus.mem_req_ready) begin
            bus.mem_req_valid  <= 1'b0;
            bus.cpu_resp_rdata <= '0;
            bus.cpu_resp_valid <= 1'b1;
            state              <= RESPOND;
          end
        end
        REFILL_REQ: begin
          if (bus.mem_req_ready) begin
            bus.mem_req_valid <= 1'b0;
            state             <= REFILL_WAIT;
          end
        end
        REFILL_WAIT: begin
          if (bus.mem_resp_valid) begin
            tag_q[fill_line]   <= req_tag;
            valid_q[fill_line] <= 1'b1;
`ifdef CACHE_PLRU_EN
            plru_q[req_set] <= plru_touch(plru_q[req_set], victim_q);
`else
            if (valid_q[fill_line]) rr_q[req_set] <= rr_q[req_set] + 2'd1;
`endif
            // Answer from the refill beat itself; the array write lands this same edge.
            bus.cpu_resp_rdata <= bus.mem_resp_data[{req_word, 5'd0} +: 32];
            bus.cpu_resp_valid <= 1'b1;
            state              <= RESPOND;
          end
        end
        RESPOND: begin
          bus.cpu_req_ready <= 1'b1;
          state             <= IDLE;
        end
        default: begin
          bus.cpu_req_ready <= 1'b1;
          state             <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cache_controller.sv
// Scoreboard bench for cache_controller: directed loads/stores, a behavioural data array,
// and an auto-responding memory; monitors pop expected CPU, memory and array events.
module tb_cache_controller;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  cache_controller_if bus ();
  logic [31:0]  we_w [8];
  logic [255:0] blk;
  logic [255:0] arr [8];
  logic [2:0]   dbg_state;

  cache_controller dut (
    .clk(clk), .reset(reset), .bus(bus),
    .we0(we_w[0]), .we1(we_w[1]), .we2(we_w[2]), .we3(we_w[3]),
    .we4(we_w[4]), .we5(we_w[5]), .we6(we_w[6]), .we7(we_w[7]),
    .block(blk),
    .blockOut0(arr[0]), .blockOut1(arr[1]), .blockOut2(arr[2]), .blockOut3(arr[3]),
    .blockOut4(arr[4]), .blockOut5(arr[5]), .blockOut6(arr[6]), .blockOut7(arr[7]),
    .dbg_state(dbg_state)
  );

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int accept_cyc = 0;

  logic [31:0]  exp_q [$];
  int           lat_q [$];
  logic [68:0]  mexp_q [$];
  logic [290:0] wexp_q [$];
  logic [255:0] refill_q [$];

  int   ready_delay = 0;
  bit   suppress_resp = 1'b0;
  bit   manual_pulse = 1'b0;
  bit   stall_en = 1'b0;
  int   stall_obs = 0;

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  always @(posedge clk) cyc++;

  // Behavioural data array: per-byte enables from the controller.
  initial for (int i = 0; i < 8; i++) arr[i] = '0;
  always @(posedge clk)
    for (int i = 0; i < 8; i++)
      for (int b = 0; b < 32; b++)
        if (we_w[i][b]) arr[i][b*8 +: 8] <= blk[b*8 +: 8];

  // Memory responder: ready after ready_delay stall cycles, refill two cycles after a read handshake.
  int           stall_cnt = 0;
  int           resp_cd = 0;
  bit           was_write = 1'b0;
  logic [255:0] pending_line = '0;
  always @(posedge clk) begin
    #1;
    bus.mem_resp_valid = 1'b0;
    if (resp_cd > 0) begin
      resp_cd--;
      if (resp_cd == 0) begin
        bus.mem_resp_valid = 1'b1;
        bus.mem_resp_data  = pending_line;
      end
    end
    if (manual_pulse) begin
      bus.mem_resp_valid = 1'b1;
      bus.mem_resp_data  = {8{32'h5555_AAAA}};
      manual_pulse = 1'b0;
    end
    if (bus.mem_req_ready) begin
      bus.mem_req_ready = 1'b0;
      stall_cnt = 0;
      if (!was_write && !suppress_resp) begin
        pending_line = (refill_q.size() > 0) ? refill_q.pop_front() : '0;
        resp_cd = 2;
      end
    end else if (bus.mem_req_valid === 1'b1 && !reset) begin
      if (stall_cnt >= ready_delay) begin
        bus.mem_req_ready = 1'b1;
        was_write = bus.mem_req_write;
      end else begin
        stall_cnt++;
      end
    end
  end

  // CPU response monitor
  always @(negedge clk) begin
    if (!reset && bus.cpu_resp_valid) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL resp_unexpected: got rdata %0h expected no response", bus.cpu_resp_rdata);
      end else begin
        logic [31:0] e;
        int l;
        e = exp_q.pop_front();
        l = lat_q.pop_front();
        check("resp_rdata", bus.cpu_resp_rdata, e);
        if (l >= 0) check("resp_latency", 256'(cyc - accept_cyc), 256'(l));
      end
    end
  end

  // Memory request monitor (handshake cycles)
  always @(negedge clk) begin
    if (!reset && bus.mem_req_valid && bus.mem_req_ready) begin
      if (mexp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL mem_unexpected: got addr %0h write %0b expected no request", bus.mem_req_addr, bus.mem_req_write);
      end else begin
        logic [68:0] e;
        e = mexp_q.pop_front();
        check("mem_write", bus.mem_req_write, e[68]);
        check("mem_addr", bus.mem_req_addr, e[67:36]);
        if (e[68]) begin
          check("mem_wdata", bus.mem_req_wdata, e[35:4]);
          check("mem_be", bus.mem_req_be, e[3:0]);
        end
      end
    end
  end

  // Array write monitor
  always @(negedge clk) begin
    if (!reset) begin
      int n;
      int idx;
      n = 0;
      idx = 0;
      for (int i = 0; i < 8; i++)
        if (we_w[i] != 32'd0) begin
          n++;
          idx = i;
        end
      if (n > 1) begin
        checks++;
        failures++;
        $display("FAIL we_multi: got %0d nonzero enables expected at most 1", n);
      end else if (n == 1) begin
        if (wexp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL we_unexpected: got line %0d we %0h expected no write", idx, we_w[idx]);
        end else begin
          logic [290:0] e;
          e = wexp_q.pop_front();
          check("we_line", 256'(idx), 256'(e[290:288]));
          check("we_value", we_w[idx], e[287:256]);
          check("we_block", blk, e[255:0]);
        end
      end
    end
  end

  // Stall monitor: payload and cpu_req_ready while memory withholds ready
  always @(negedge clk) begin
    if (stall_en && !reset && bus.mem_req_valid && !bus.mem_req_ready) begin
      stall_obs++;
      check("stall_addr", bus.mem_req_addr, 32'h0000_2000);
      check("stall_wdata", bus.mem_req_wdata, 32'hA5A5_5A5A);
      check("stall_cpu_ready", bus.cpu_req_ready, 1'b0);
    end
  end

  task automatic expect_resp(input logic [31:0] d, input int lat);
    exp_q.push_back(d);
    lat_q.push_back(lat);
  endtask

  task automatic expect_mem(input logic w, input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
    mexp_q.push_back({w, a, d, be});
  endtask

  task automatic expect_we(input logic [2:0] line, input logic [31:0] we, input logic [255:0] b);
    wexp_q.push_back({line, we, b});
  endtask

  task automatic issue(input logic w, input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
    int n;
    n = 0;
    while (bus.cpu_req_ready !== 1'b1 && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 100) begin
      checks++;
      failures++;
      $display("FAIL req_ready_timeout: got ready %b expected 1", bus.cpu_req_ready);
    end
    bus.cpu_req_valid = 1'b1;
    bus.cpu_req_write = w;
    bus.cpu_req_addr  = a;
    bus.cpu_req_wdata = d;
    bus.cpu_req_be    = be;
    accept_cyc = cyc;
    @(posedge clk); #1;
    bus.cpu_req_valid = 1'b0;
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    while ((exp_q.size() != 0 || dbg_state != 3'd0) && n < 300) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 300) begin
      checks++;
      failures++;
      $display("FAIL done_timeout: got state %0d pending %0d expected idle", dbg_state, exp_q.size());
    end
  endtask

  function automatic logic [255:0] mk_line(input logic [31:0] base);
    logic [255:0] l;
    for (int i = 0; i < 8; i++) l[i*32 +: 32] = base + 32'(i);
    return l;
  endfunction

  task automatic load_miss(input logic [31:0] a, input logic [255:0] line, input logic [2:0] vline,
                           input logic [31:0] exp_word);
    expect_mem(1'b0, {a[31:5], 5'd0}, 32'd0, 4'd0);
    refill_q.push_back(line);
    expect_we(vline, 32'hFFFF_FFFF, line);
    expect_resp(exp_word, -1);
    issue(1'b0, a, 32'd0, 4'd0);
    wait_done();
  endtask

  task automatic load_hit(input logic [31:0] a, input logic [31:0] exp_word);
    expect_resp(exp_word, 2);
    issue(1'b0, a, 32'd0, 4'd0);
    wait_done();
  endtask

  task automatic store(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be,
                       input bit is_hit, input logic [2:0] line, input logic [31:0] we_exp);
    if (is_hit) expect_we(line, we_exp, {8{d}});
    expect_mem(1'b1, a, d, be);
    expect_resp(32'd0, 3 + ready_delay);
    issue(1'b1, a, d, be);
    wait_done();
  endtask

  logic [255:0] l0;
  logic [2:0]   second_victim;

  initial begin
    bus.cpu_req_valid  = 1'b0;
    bus.cpu_req_write  = 1'b0;
    bus.cpu_req_addr   = '0;
    bus.cpu_req_wdata  = '0;
    bus.cpu_req_be     = '0;
    bus.mem_req_ready  = 1'b0;
    bus.mem_resp_valid = 1'b0;
    bus.mem_resp_data  = '0;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;

    check("rst_cpu_ready", bus.cpu_req_ready, 1'b1);
    check("rst_resp_valid", bus.cpu_resp_valid, 1'b0);
    check("rst_resp_rdata", bus.cpu_resp_rdata, 32'd0);
    check("rst_mem_valid", bus.mem_req_valid, 1'b0);
    check("rst_we_any", 256'(we_w[0] | we_w[1] | we_w[2] | we_w[3] | we_w[4] | we_w[5] | we_w[6] | we_w[7]), 256'd0);
    check("rst_block", blk, 256'd0);
    check("rst_state", dbg_state, 3'd0);

    l0 = mk_line(32'h1000_0000);
    l0[63:32] = 32'hDEAD_BEEF;
    l0[95:64] = 32'hDEAD_0002;
    load_miss(32'h0000_0044, l0, 3'd0, 32'hDEAD_BEEF);
    load_hit(32'h0000_0044, 32'hDEAD_BEEF);
    store(32'h0000_0048, 32'h1234_5678, 4'b0011, 1'b1, 3'd0, 32'h0000_0300);
    load_hit(32'h0000_0048, 32'hDEAD_5678);
    store(32'h0000_1000, 32'hCAFE_F00D, 4'b1111, 1'b0, 3'd0, 32'd0);

    load_miss(32'h0000_0000, mk_line(32'h2000_0000), 3'd1, 32'h2000_0000);
    load_miss(32'h0000_0088, mk_line(32'h3000_0000), 3'd2, 32'h3000_0002);
    load_miss(32'h0000_00CC, mk_line(32'h4000_0000), 3'd3, 32'h4000_0003);
    load_hit(32'h0000_0004, 32'h2000_0001);
    load_hit(32'h0000_0080, 32'h3000_0000);
    load_hit(32'h0000_00DC, 32'h4000_0007);
    load_miss(32'h0000_0064, mk_line(32'h5000_0000), 3'd4, 32'h5000_0001);
    load_miss(32'h0000_0110, mk_line(32'h6000_0000), 3'd0, 32'h6000_0004);
`ifdef CACHE_PLRU_EN
    second_victim = 3'd2;
`else
    second_victim = 3'd1;
`endif
    load_miss(32'h0000_0044, mk_line(32'h7000_0000), second_victim, 32'h7000_0001);
    load_hit(32'h0000_00C0, 32'h4000_0000);
    load_hit(32'h0000_0070, 32'h5000_0004);

    // Memory withholds ready for 10 cycles; a CPU request raised meanwhile must be ignored.
    ready_delay = 10;
    stall_en = 1'b1;
    stall_obs = 0;
    expect_mem(1'b1, 32'h0000_2000, 32'hA5A5_5A5A, 4'b1001);
    expect_resp(32'd0, 13);
    issue(1'b1, 32'h0000_2000, 32'hA5A5_5A5A, 4'b1001);
    repeat (2) @(posedge clk);
    #1;
    bus.cpu_req_valid = 1'b1;
    bus.cpu_req_write = 1'b0;
    bus.cpu_req_addr  = 32'h0000_0044;
    repeat (3) @(posedge clk);
    #1;
    bus.cpu_req_valid = 1'b0;
    wait_done();
    stall_en = 1'b0;
    ready_delay = 0;
    check("stall_cycles", 256'(stall_obs), 256'd10);

    // Reset while waiting for a refill; a late beat must not write or respond.
    suppress_resp = 1'b1;
    expect_mem(1'b0, 32'h0000_0300, 32'd0, 4'd0);
    issue(1'b0, 32'h0000_0300, 32'd0, 4'd0);
    begin
      int n;
      n = 0;
      while (dbg_state != 3'd4 && n < 50) begin
        @(posedge clk); #1;
        n++;
      end
      if (n >= 50) begin
        checks++;
        failures++;
        $display("FAIL refill_wait_timeout: got state %0d expected 4", dbg_state);
      end
    end
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    check("midrst_mem_valid", bus.mem_req_valid, 1'b0);
    check("midrst_cpu_ready", bus.cpu_req_ready, 1'b1);
    check("midrst_state", dbg_state, 3'd0);
    manual_pulse = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    suppress_resp = 1'b0;
    load_miss(32'h0000_00C4, mk_line(32'h8000_0000), 3'd0, 32'h8000_0001);
    load_miss(32'h0000_0048, mk_line(32'h9000_0000), 3'd1, 32'h9000_0002);

    repeat (4) @(posedge clk);
    #1;
    check("left_resp", 256'(exp_q.size()), 256'd0);
    check("left_mem", 256'(mexp_q.size()), 256'd0);
    check("left_we", 256'(wexp_q.size()), 256'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    failures++;
    $display("FAIL watchdog: got no completion expected finish before time limit");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/cache_controller.md
# cache_controller

Sequencing controller for the 4-way set-associative cache data array (8 lines of 256 bits = 2 sets × 4 ways, line index = set*4 + way). It holds tags, valid bits and replacement state, accepts one CPU word request at a time, and drives the array's per-byte write enables and write block for write hits and line refills. Write-through, no-write-allocate, blocking; it sits between the CPU load/store port and the memory bus.

## Interface
- No parameters; geometry fixed: 32-byte line, 2 sets, 4 ways; addr[4:0] offset, addr[5] set, addr[31:6] tag (26 bits).
- clk  in  1  clock, all state on rising edge
- reset  in  1  synchronous, active-high
- cpu_req_valid / cpu_req_ready  in / out  1  request handshake
- cpu_req_write  in  1  1 = store, 0 = load
- cpu_req_addr  in  32  byte address; addr[1:0] ignored
- cpu_req_wdata  in  32  store data
- cpu_req_be  in  4  store byte enables
- cpu_resp_valid  out  1  one-cycle response pulse
- cpu_resp_rdata  out  32  load data; 0 for stores
- mem_req_valid / mem_req_ready  out / in  1  memory request handshake
- mem_req_write  out  1  1 = word write, 0 = line read
- mem_req_addr  out  32  word address (write) or line-aligned address, [4:0]=0 (read)
- mem_req_wdata / mem_req_be  out  32 / 4  store passthrough
- mem_resp_valid  in  1  refill data valid, one cycle
- mem_resp_data  in  256  refill line, byte 0 in [7:0]
- we0..we7  out  32 each  per-byte write enables to array line 0..7
- block  out  256  write data to array
- blockOut0..blockOut7  in  256 each  array read data, combinational from array state

## Operation
- States: IDLE, LOOKUP, MEM_WRITE, REFILL_REQ, REFILL_WAIT, RESPOND.
- IDLE: cpu_req_ready=1; on valid&ready latch request → LOOKUP. Ready is 0 in every other state; requests are ignored.
- LOOKUP: compare latched tag against the 4 ways of the set (valid & tag equal).
  - Read hit: latch word addr[4:2] of the hit line, update replacement → RESPOND.
  - Write hit: for one cycle drive we(set*4+way) = cpu_req_be << (4*addr[4:2]), block = wdata replicated ×8, update replacement → MEM_WRITE.
  - Write miss: no array write → MEM_WRITE.
  - Read miss: pick victim → REFILL_REQ.
- MEM_WRITE: mem_req_valid=1, write=1; hold addr/wdata/be stable until mem_req_ready sampled high → RESPOND.
- REFILL_REQ: mem_req_valid=1, write=0, line address; on ready → REFILL_WAIT.
- REFILL_WAIT: on mem_resp_valid, for that cycle drive block=mem_resp_data, victim we=32'hFFFF_FFFF; set tag, valid; update replacement; latch requested word → RESPOND. mem_resp_valid in any other state is ignored.
- RESPOND: cpu_resp_valid=1 for one cycle → IDLE.
- Victim: lowest-index invalid way first; if all valid, replacement policy (see Configuration).
- we0..we7 are zero in every cycle not listed above; at most one is nonzero per cycle.

## Timing
- Reset: state IDLE, all valid bits and replacement state cleared, cpu_req_ready=1 is the only asserted output; cpu_resp_valid, mem_req_valid, we*, block, rdata all 0. Array contents are not cleared.
- Reset mid-operation (any state) aborts: mem_req_valid and we* drop the cycle after reset is sampled; the pending request gets no response. Reset has priority over every other event.
- Read hit: accept at cycle 0, resp_valid at cycle 2.
- Write: resp_valid 1 cycle after the mem handshake completes (ready=1 at cycle 2 → resp at cycle 3).
- Read miss: resp_valid 1 cycle after the mem_resp_valid cycle; the refilled word is returned, not reread from the array.
- All outputs registered except we*/block, which are decoded from state.

## Configuration
- CACHE_PLRU_EN defined: 3-bit tree pseudo-LRU per set, updated on every hit and fill; victim = way the tree points at.
- Undefined: 2-bit round-robin counter per set, incremented only on fills that replace a valid line; victim = counter value.

## Test plan
- Reset, then load 0x0000_0044 → miss, mem_req_addr=0x0000_0040; refill with word1=0xDEADBEEF → we1=0 for set1? No: set=addr[5]=0, way0 → we0=32'hFFFF_FFFF once, resp_rdata=0xDEADBEEF; repeat load → hit, resp at cycle 2, no mem_req.
- Store 0x0000_0048, be=4'b0011, wdata=0x1234_5678 after above fill → we0=32'h0000_0300, mem write issued; reload → 0xDEAD5678 word2 merged correctly.
- Store to uncached 0x0000_1000 → no we*, mem write only, resp_rdata=0.
- Fill set0 with tags 0..4 (5 distinct lines) → first 4 fill ways 0..3, fifth evicts way chosen by policy (PLRU: way0 after hits on 1,2,3; RR: way0).
- mem_req_ready held low 10 cycles → mem_req_valid and mem_req_addr stable, cpu_req_ready=0 throughout.
- Assert reset in REFILL_WAIT, then pulse mem_resp_valid → no we*, no resp, all valid bits 0.
